cf_fft_1024_8_twiddle_mul: RTL and testbench
============================================

CF_FFT_1024_8_TWIDDLE_MUL -- requirements
Module: cf_fft_1024_8_twiddle_mul

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock_c, the single clock with all state on its rising edge; i5, the reset, synchronous and active-high.
REQ-002 clock_c  input  1  sole clock.
REQ-003 i5  input  1  synchronous active-high reset.
REQ-004 i4  input  1  clock enable; all state advances only on cycles with i4=1.
REQ-005 i1  input  1  frame start; marks the sample at index k=0.
REQ-006 i2  input  16  real part of the input sample, two's complement Q1.15.
REQ-007 i3  input  16  imaginary part of the input sample, two's complement Q1.15.
REQ-008 o1  output  1  frame start, delayed in step with the data.
REQ-009 o2  output  16  real part of the result, Q1.15.
REQ-010 o3  output  16  imaginary part of the result, Q1.15.

Function
REQ-011 Position in the pipeline: downstream of the radix-2 butterfly stage; applies the twiddle factor to each sample of a 1024-sample frame before the next butterfly stage.
REQ-012 Sample counter: 10-bit k.
- Effective index k_eff = 0 when i1=1, else k.
- On each enabled cycle, k <= k_eff+1, modulo 1024 (1023 wraps to 0).
REQ-013 Twiddle index t:
- t = k_eff[8:0] when k_eff[9]=1.
- Otherwise the sample SHALL bypass, i.e. pass through unchanged.
- t=0 SHALL also bypass.
REQ-014 Twiddle ROM: 512 entries, synchronous read.
- c(t) = round(32767*cos(2*pi*t/1024)).
- s(t) = round(32767*sin(2*pi*t/1024)).
REQ-015 Multiply, with W = c - j*s:
- yr = xr*c + xi*s; yi = xi*c - xr*s.
- Products are full 32-bit signed; sums are 33-bit signed with no intermediate truncation.
REQ-016 Rounding: add 2^14, then arithmetic right shift by 15.
REQ-017 Saturation: saturate to [-32768, 32767], i.e. 0x8000..0x7FFF.
REQ-018 Latency: exactly 4 enabled cycles from input (i1,i2,i3) to output (o1,o2,o3), for both the bypass and the multiply paths.
REQ-019 o1 SHALL be i1 passed through a matching 4-stage delay line.
REQ-020 Enable: with i4=0, the counter, ROM register, pipeline registers and outputs SHALL hold their values.
REQ-021 Restart mid-frame: i1=1 at any k SHALL force k_eff=0 for that sample. In-flight samples complete normally; no output is dropped or duplicated.
REQ-022 Simultaneous i5=1 and i4=1: reset wins.
REQ-023 Throughput: one sample per enabled cycle; no back-pressure.

Reset
REQ-024 On a clock edge with i5=1, regardless of i4, the following SHALL clear to zero: k, all pipeline registers, the start delay line, and o1/o2/o3.
REQ-025 Outputs SHALL read o1=0, o2=0x0000, o3=0x0000 from the first edge after reset until valid data has traversed the 4-stage pipeline.
REQ-026 Reset asserted mid-frame SHALL discard all in-flight samples; counting resumes from k=0.
REQ-027 Initial register values at power-up SHALL equal the reset values.

Verification
REQ-028 Reset: i5=1 for 2 cycles with i4=1 and random data -> o1=0, o2=0x0000, o3=0x0000 on both cycles and until new data arrives.
REQ-029 Bypass: i1=1, x=(0x4000,0x0000) at k=0, i4=1 constantly -> 4 cycles later o1=1, o2=0x4000, o3=0x0000.
REQ-030 Multiply: drive a frame; at k=768 (t=256, c=0, s=0x7FFF), x=(0x4000,0x0000) -> o2=0x0000, o3=0xC001.
REQ-031 Saturation: at k=640 (t=128, c=s=0x5A82), x=(0x8000,0x8000) -> o2=0x8000 (saturated), o3=0x0000.
REQ-032 Enable stall: drop i4 to 0 for 3 cycles mid-frame -> o1/o2/o3 frozen; after i4 returns, the output sequence is identical to the unstalled run.
REQ-033 Restart and wrap: i1=1 at k=600 -> that sample bypasses with 4-cycle latency, o1 pulses once; additionally, a frame of 1030 samples with no restart wraps k 1023->0 and sample 1024 bypasses.

Source files
------------

// File: rtl/cf_fft_1024_8_twiddle_mul_if.sv
// Sample stream interface for the FFT twiddle multiplier.
//   i4     : clock enable
//   i1     : frame start (sample k=0)
//   i2/i3  : input sample real/imag, Q1.15
//   o1     : frame start, delayed with the data
//   o2/o3  : result real/imag, Q1.15
// master drives the inputs and observes the results; slave is the multiplier.
interface cf_fft_1024_8_twiddle_mul_if;
  logic        i4;
  logic        i1;
  logic [15:0] i2;
  logic [15:0] i3;
  logic        o1;
  logic [15:0] o2;
  logic [15:0] o3;

  modport master (output i4, i1, i2, i3, input o1, o2, o3);
  modport slave  (input i4, i1, i2, i3, output o1, o2, o3);
endinterface

// File: rtl/cf_fft_1024_8_twiddle_mul.sv
// Twiddle-factor multiplier placed between radix-2 butterfly stages of a
// 1024-point FFT. Each sample x of a frame is multiplied by W = c - j*s for
// the second half of the frame (twiddle index t = k[8:0], t != 0); all other
// samples pass through unchanged. Fixed 4-enable-cycle latency on both paths.
// Ports:
//   clock_c : sole clock, rising edge
//   i5      : synchronous active-high reset (wins over the enable)
//   bus     : sample stream (enable, frame start, data in, data out)
module cf_fft_1024_8_twiddle_mul (
  input  logic                              clock_c,
  input  logic                              i5,
  cf_fft_1024_8_twiddle_mul_if.slave        bus
);

  // Twiddle value round(32767*cos/sin(2*pi*t/1024)), rounded half away from zero.
  function automatic logic [15:0] tw_q15(input int t, input logic sine);
    real a;
    real v;
    a = 2.0 * 3.14159265358979323846 * $itor(t) / 1024.0;
    v = sine ? 32767.0 * $sin(a) : 32767.0 * $cos(a);
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    else          return 16'(-$rtoi(0.5 - v));
  endfunction

  // Round-shifted sum is bits [32:15]; clamp it into the Q1.15 range.
  function automatic logic [15:0] sat16(input logic signed [32:0] v);
    logic signed [17:0] q;
    q = v[32:15];
    if (q > 18'sd32767)       return 16'h7FFF;
    else if (q < -18'sd32768) return 16'h8000;
    else                      return q[15:0];
  endfunction

  // Constant twiddle table {c, s}, indexed by t.
  logic [31:0] rom_c [512];
  for (genvar g = 0; g < 512; g++) begin : g_rom
    assign rom_c[g] = {tw_q15(g, 1'b0), tw_q15(g, 1'b1)};
  end

  logic [9:0] k;
  logic [9:0] k_eff;
  logic       byp0;

  logic               s1_f, s1_byp;
  logic signed [15:0] s1_xr, s1_xi, s1_c, s1_s;

  logic               s2_f, s2_byp;
  logic        [15:0] s2_xr, s2_xi;
  logic signed [31:0] p_xc, p_xs, p_yc, p_ys;

  logic               s3_f, s3_byp;
  logic        [15:0] s3_xr, s3_xi;
  logic signed [32:0] s3_yr, s3_yi;

  logic signed [32:0] sum_r, sum_i;

  logic        o1_q;
  logic [15:0] o2_q, o3_q;

  // Index of the current sample; a frame start forces it back to 0.
  always_comb begin
    k_eff = bus.i1 ? '0 : k;
    byp0  = ~k_eff[9] | (k_eff[8:0] == 9'd0);
  end

  // Full-width sums with the rounding constant folded in.
  always_comb begin
    sum_r = $signed({p_xc[31], p_xc}) + $signed({p_ys[31], p_ys}) + 33'sd16384;
    sum_i = $signed({p_yc[31], p_yc}) - $signed({p_xs[31], p_xs}) + 33'sd16384;
  end

  always_ff @(posedge clock_c) begin
    if (i5) begin
      k      <= '0;
      s1_f   <= '0;
      s1_byp <= '0;
      s1_xr  <= '0;
      s1_xi  <= '0;
      s1_c   <= '0;
      s1_s   <= '0;
      s2_f   <= '0;
      s2_byp <= '0;
      s2_xr  <= '0;
      s2_xi  <= '0;
      p_xc   <= '0;
      p_xs   <= '0;
      p_yc   <= '0;
      p_ys   <= '0;
      s3_f   <= '0;
      s3_byp <= '0;
      s3_xr  <= '0;
      s3_xi  <= '0;
      s3_yr  <= '0;
      s3_yi  <= '0;
      o1_q   <= '0;
      o2_q   <= '0;
      o3_q   <= '0;
    end else if (bus.i4) begin
      k <= k_eff + 10'd1;

      // Stage 1: synchronous table read alongside the captured sample.
      {s1_c, s1_s} <= rom_c[k_eff[8:0]];
      s1_f         <= bus.i1;
      s1_byp       <= byp0;
      s1_xr        <= bus.i2;
      s1_xi        <= bus.i3;

      // Stage 2: four signed 16x16 products.
      p_xc   <= s1_xr * s1_c;
      p_xs   <= s1_xr * s1_s;
      p_yc   <= s1_xi * s1_c;
      p_ys   <= s1_xi * s1_s;
      s2_f   <= s1_f;
      s2_byp <= s1_byp;
      s2_xr  <= s1_xr;
      s2_xi  <= s1_xi;

      // Stage 3: rounded 33-bit sums.
      s3_yr  <= sum_r;
      s3_yi  <= sum_i;
      s3_f   <= s2_f;
      s3_byp <= s2_byp;
      s3_xr  <= s2_xr;
      s3_xi  <= s2_xi;

      // Stage 4: bypass select or shift/saturate into the output register.
      o1_q <= s3_f;
      o2_q <= s3_byp ? s3_xr : sat16(s3_yr);
      o3_q <= s3_byp ? s3_xi : sat16(s3_yi);
    end
  end

  assign bus.o1 = o1_q;
  assign bus.o2 = o2_q;
  assign bus.o3 = o3_q;

endmodule

// File: tb/tb_cf_fft_1024_8_twiddle_mul.sv
module tb_cf_fft_1024_8_twiddle_mul;

  typedef struct packed {
    logic        f;
    logic [15:0] r;
    logic [15:0] i;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   kb = 0;
  exp_t q[$];

  cf_fft_1024_8_twiddle_mul_if bus();

  cf_fft_1024_8_twiddle_mul dut (
    .clock_c (clk),
    .i5      (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Directed input per sample index with its hand-computed result.
  function automatic void vec(input int k, output logic [15:0] xr, output logic [15:0] xi,
                              output logic [15:0] er, output logic [15:0] ei);
    case (k)
      0:   begin xr = 16'h4000; xi = 16'h0000; er = 16'h4000; ei = 16'h0000; end
      513: begin xr = 16'h7FFF; xi = 16'h0000; er = 16'h7FFD; ei = 16'hFF37; end
      640: begin xr = 16'h8000; xi = 16'h8000; er = 16'h8000; ei = 16'h0000; end
      768: begin xr = 16'h4000; xi = 16'h0000; er = 16'h0000; ei = 16'hC001; end
      896: begin xr = 16'h4000; xi = 16'h0000; er = 16'hD2BF; ei = 16'hD2BF; end
      default: begin
        if (k <= 512) begin
          xr = 16'(k * 37 + 5);
          xi = 16'(k) ^ 16'hA5A5;
          er = xr;
          ei = xi;
        end else begin
          xr = 16'h0000; xi = 16'h0000; er = 16'h0000; ei = 16'h0000;
        end
      end
    endcase
  endfunction

  task automatic send(input logic f);
    int          ke;
    logic [15:0] xr, xi, er, ei;
    exp_t        e;
    ke = f ? 0 : kb;
    vec(ke, xr, xi, er, ei);
    bus.i1 = f;
    bus.i2 = xr;
    bus.i3 = xi;
    bus.i4 = 1'b1;
    e.f = f;
    e.r = er;
    e.i = ei;
    q.push_back(e);
    @(negedge clk);
    kb = (ke + 1) % 1024;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      bus.i4 = 1'b0;
      bus.i1 = 1'($urandom);
      bus.i2 = 16'($urandom);
      bus.i3 = 16'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input exp_t want);
    exp_t got;
    got.f = bus.o1;
    got.r = bus.o2;
    got.i = bus.o3;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got o1=%0b o2=%h o3=%h want o1=%0b o2=%h o3=%h",
               name, $time, got.f, got.r, got.i, want.f, want.r, want.i);
    end
  endtask

  // Monitor: after every edge, the output equals the sample accepted three
  // enabled edges earlier, zero while the pipeline refills, held otherwise.
  initial begin
    int   n;
    logic en_s, rst_s;
    exp_t last, e;
    n    = 0;
    last = '0;
    forever begin
      @(posedge clk);
      en_s  = bus.i4;
      rst_s = rst;
      #1;
      if (rst_s === 1'b1) begin
        n = 0;
        q.delete();
        last = '0;
        chk("reset", last);
      end else if (en_s === 1'b1) begin
        n++;
        if (n <= 3) begin
          last = '0;
          chk("fill", last);
        end else if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow t=%0t got no expected entry want one queued", $time);
        end else begin
          e = q.pop_front();
          last = e;
          chk("data", last);
        end
      end else begin
        chk("hold", last);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    bus.i4 = 1'b1;
    bus.i1 = 1'($urandom);
    bus.i2 = 16'($urandom);
    bus.i3 = 16'($urandom);
    @(negedge clk);
    bus.i2 = 16'($urandom);
    bus.i3 = 16'($urandom);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // 1030-sample frame with a 3-cycle stall; wraps k 1023->0.
    kb = 0;
    send(1'b1);
    for (int j = 1; j < 1030; j++) begin
      if (j == 300) idle(3);
      send(1'b0);
    end

    // Run up to k=600, restart there, then cover the multiply points again.
    while (kb != 600) send(1'b0);
    send(1'b1);
    for (int j = 0; j < 900; j++) send(1'b0);

    // Reset mid-frame with samples in flight; counting resumes from 0.
    rst    = 1'b1;
    bus.i4 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kb  = 0;
    idle(2);
    for (int j = 0; j < 771; j++) send(1'b0);
    for (int j = 0; j < 3; j++) send(1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
